// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU operand sequencer and its register file.
package alu_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_CNT_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_NOT = 1'b1;

  typedef enum logic [1:0] {IDLE, OPERAND, EXECUTE, WRITEBACK} state_t;
endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; r0 is never written, so it always reads zero.
module alu_regfile #(
  parameter int DATA_W  = alu_pkg::DATA_W_DEF,
  parameter int REG_CNT = alu_pkg::REG_CNT_DEF,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [REG_CNT-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    regs <= '0;
    else if (we && waddr != '0)    regs[waddr] <= wdata;
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequencer around an external combinational NOT/ADD ALU: accepts one
// instruction, fetches operands, captures the result and writes it back.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_CNT = REG_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic              instr_sel,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_select,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  op_count
);
  state_t state, state_nxt;

  logic [AW-1:0]     rd_q, rs1_q, rs2_q, wb_rd_q;
  logic              isel_q, sel_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, rf_a, rf_b;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;

  assign accept = (state == IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = instr_load ? WRITEBACK : OPERAND;
      end
      OPERAND:   state_nxt = EXECUTE;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // wb_rd_q is separate from rd_q so the reported destination holds while
  // the next instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      isel_q  <= SEL_ADD;
      sel_q   <= SEL_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      wb_rd_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rd_q   <= instr_rd;
          rs1_q  <= instr_rs1;
          rs2_q  <= instr_rs2;
          isel_q <= instr_sel;
          if (instr_load) begin
            res_q   <= instr_imm;
            wb_rd_q <= instr_rd;
          end
        end
        OPERAND: begin
          a_q   <= rf_a;
          b_q   <= rf_b;
          sel_q <= isel_q;
        end
        EXECUTE: begin
          res_q   <= alu_result;
          wb_rd_q <= rd_q;
        end
        WRITEBACK: cnt_q <= cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  alu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == WRITEBACK),
    .waddr    (rd_q),
    .wdata    (res_q),
    .ra_addr  (rs1_q),
    .ra_data  (rf_a),
    .rb_addr  (rs2_q),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = sel_q;
  assign wb_valid   = (state == WRITEBACK);
  assign wb_rd      = wb_rd_q;
  assign wb_data    = res_q;
  assign op_count   = cnt_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural NOT/ADD ALU.
module tb_alu_operand_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0, instr_ready;
  logic        instr_load = 1'b0, instr_sel = 1'b0;
  logic [2:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [31:0] instr_imm = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_select;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [15:0] op_count;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign alu_result = alu_select ? ~alu_a : alu_a + alu_b;

  alu_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_load(instr_load), .instr_sel(instr_sel),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .op_count(op_count)
  );

  typedef struct {
    logic        load;
    logic        sel;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    int          lat;
    logic [2:0]  dbg_a;
    logic [31:0] dbg_e;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[12];
  vec_t hv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_load = v.load;
    instr_sel  = v.sel;
    instr_rd   = v.rd;
    instr_rs1  = v.rs1;
    instr_rs2  = v.rs2;
    instr_imm  = v.imm;
  endtask

  task automatic issue(input vec_t v, input int i);
    int n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("v%0d ready", i), {31'b0, instr_ready}, 32'd1);
    drive(v);
    instr_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      instr_valid = 1'b0;
      n++;
    end while (!wb_valid && n < 10);
    chk($sformatf("v%0d latency", i), n, v.lat);
    chk($sformatf("v%0d wb_rd", i), {29'b0, wb_rd}, {29'b0, v.rd});
    chk($sformatf("v%0d wb_data", i), wb_data, v.exp);
    @(negedge clk);
    dbg_addr = v.dbg_a;
    #1;
    chk($sformatf("v%0d wb_hold", i), {wb_data[31:1], wb_valid}, {v.exp[31:1], 1'b0});
    chk($sformatf("v%0d dbg", i), dbg_data, v.dbg_e);
    chk($sformatf("v%0d op_count", i), {16'b0, op_count}, {16'b0, v.cnt});
  endtask

  initial begin
    //             load sel rd   rs1   rs2   imm           exp           lat dbg   dbg_e         cnt
    vt[0]  = '{1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 32'd5,        32'd5,        1, 3'd1, 32'd5,        16'd1};
    vt[1]  = '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 32'd7,        32'd7,        1, 3'd2, 32'd7,        16'd2};
    vt[2]  = '{1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 32'd0,        32'h0000000C, 3, 3'd3, 32'd12,       16'd3};
    vt[3]  = '{1'b0, 1'b1, 3'd4, 3'd1, 3'd0, 32'd0,        32'hFFFFFFFA, 3, 3'd4, 32'hFFFFFFFA, 16'd4};
    vt[4]  = '{1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3'd1, 32'hFFFFFFFF, 16'd5};
    vt[5]  = '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 32'd1,        32'd1,        1, 3'd2, 32'd1,        16'd6};
    vt[6]  = '{1'b0, 1'b0, 3'd5, 3'd1, 3'd2, 32'd0,        32'h00000000, 3, 3'd5, 32'd0,        16'd7};
    vt[7]  = '{1'b0, 1'b0, 3'd6, 3'd5, 3'd1, 32'd0,        32'hFFFFFFFF, 3, 3'd6, 32'hFFFFFFFF, 16'd8};
    vt[8]  = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 32'h1234,     32'h00001234, 1, 3'd0, 32'd0,        16'd9};
    vt[9]  = '{1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 32'd0,        32'd0,        3, 3'd3, 32'd0,        16'd10};
    vt[10] = '{1'b0, 1'b1, 3'd7, 3'd2, 3'd0, 32'd0,        32'hFFFFFFFE, 3, 3'd7, 32'hFFFFFFFE, 16'd11};
    vt[11] = '{1'b0, 1'b0, 3'd2, 3'd2, 3'd2, 32'd0,        32'd2,        3, 3'd2, 32'd2,        16'd12};

    hv[0]  = '{1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 32'd3,        32'd3,        1, 3'd1, 32'd3,        16'd13};
    hv[1]  = '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 32'd4,        32'd4,        1, 3'd2, 32'd4,        16'd14};
    hv[2]  = '{1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 32'd0,        32'd7,        3, 3'd3, 32'd7,        16'd15};
    hv[3]  = '{1'b0, 1'b1, 3'd4, 3'd3, 3'd0, 32'd0,        32'hFFFFFFF8, 3, 3'd4, 32'hFFFFFFF8, 16'd16};

    // reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dbg_addr = 3'd1;
    #1;
    chk("rst ready",    {31'b0, instr_ready}, 32'd1);
    chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst wb_data",  wb_data, 32'd0);
    chk("rst alu_a",    alu_a, 32'd0);
    chk("rst op_count", {16'b0, op_count}, 32'd0);
    chk("rst dbg r1",   dbg_data, 32'd0);

    for (int i = 0; i < 12; i++) issue(vt[i], i);

    // instr_valid held high across a back-to-back stream
    begin
      int wbs = 0, low = 0, cyc = 0;
      drive(hv[0]);
      instr_valid = 1'b1;
      while (wbs < 4 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (!instr_ready) low++;
        if (wb_valid) begin
          chk($sformatf("hold%0d wb_data", wbs), wb_data, hv[wbs].exp);
          wbs++;
          if (wbs < 4) drive(hv[wbs]);
          else instr_valid = 1'b0;
        end
      end
      instr_valid = 1'b0;
      chk("hold wb count", wbs, 32'd4);
      chk("hold busy cycles", low, 32'd8);
      @(negedge clk);
      dbg_addr = 3'd4;
      #1;
      chk("hold op_count", {16'b0, op_count}, 32'd16);
      chk("hold dbg r4", dbg_data, 32'hFFFFFFF8);
    end

    // reset asserted while an ADD is in EXECUTE
    begin
      int wb_seen = 0;
      drive('{1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 32'd0, 32'd7, 3, 3'd3, 32'd7, 16'd17});
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst ready", {31'b0, instr_ready}, 32'd1);
      chk("midrst wb_valid", {31'b0, wb_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (wb_valid) wb_seen++;
      end
      dbg_addr = 3'd3;
      #1;
      chk("midrst no wb", wb_seen, 32'd0);
      chk("midrst ready after", {31'b0, instr_ready}, 32'd1);
      chk("midrst r3", dbg_data, 32'd0);
      chk("midrst op_count", {16'b0, op_count}, 32'd0);
      chk("midrst wb_data", wb_data, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
